// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: core-wide fetch constants and the {pc, inst} packet
// shared by fetch, the fetch queue and decode.
package inst_fetch_queue_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_pkt_t;
endpackage

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: first-word-fall-through FIFO of {pc, inst} between fetch and decode,
// with a flush that empties it on a control-flow redirect.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN = inst_fetch_queue_pkg::XLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_inst,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] pc_mem [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic push, pop;

    // Both handshakes depend only on registered occupancy, so there is no comb path across the queue.
    assign in_ready  = count != CW'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_pc    = out_valid ? pc_mem[rd_ptr] : '0;
    assign out_inst  = out_valid ? inst_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
        end
    end

    // Storage needs no reset; a dropped push may land in a slot that the reset pointers treat as empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed checks of reset, FWFT, fill/drain, wrap, flush and mid-stream reset.
module tb_inst_fetch_queue;
    import inst_fetch_queue_pkg::*;

    logic clk = 0;
    logic rst = 1;
    logic in_valid = 0;
    logic in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic out_valid;
    logic out_ready = 0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic flush = 0;
    logic [2:0] count;
    int passes = 0;
    int total = 0;

    inst_fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            assert (count <= 3'd4) passes++;
            else $error("FAIL count_bound: observed %0d expected <= 4", count);
        end
    end

    initial begin
        tick();
        tick();
        rst = 0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);

        in_valid = 1;
        in_pc = RESET_PC;
        in_inst = INST_NOP;
        tick();
        check("push1_valid", 32'(out_valid), 32'd1);
        check("push1_pc", out_pc, 32'h8000_0000);
        check("push1_inst", out_inst, 32'h0000_0013);
        check("push1_count", 32'(count), 32'd1);

        for (int i = 1; i < 4; i++) begin
            in_pc = RESET_PC + 32'(4 * i);
            in_inst = 32'h13 | (32'(i) << 20);
            tick();
        end
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_pc = 32'h8000_0010;
        in_inst = 32'h0040_0013;
        tick();
        check("held_count", 32'(count), 32'd4);
        check("held_in_ready", 32'(in_ready), 32'd0);
        check("held_head", out_pc, 32'h8000_0000);

        in_valid = 0;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", out_pc, 32'h8000_0000 + 32'(4 * i));
            check("drain_inst", out_inst, 32'h13 | (32'(i) << 20));
            tick();
        end
        check("drained_count", 32'(count), 32'd0);
        check("drained_valid", 32'(out_valid), 32'd0);
        check("drained_pc", out_pc, 32'd0);

        in_valid = 1;
        for (int k = 0; k < 10; k++) begin
            in_pc = 32'h8000_0000 + 32'(4 * k);
            in_inst = 32'h13 | (32'(k) << 20);
            tick();
            check("stream_count", 32'(count), 32'd1);
            check("stream_pc", out_pc, 32'h8000_0000 + 32'(4 * k));
        end
        in_valid = 0;
        tick();
        check("stream_end_count", 32'(count), 32'd0);

        out_ready = 0;
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_pc = 32'h9000_0000 + 32'(4 * i);
            tick();
        end
        check("preflush_count", 32'(count), 32'd3);
        flush = 1;
        out_ready = 1;
        in_pc = 32'hDEAD_0000;
        tick();
        flush = 0;
        in_valid = 0;
        out_ready = 0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_pc", out_pc, 32'd0);
        in_valid = 1;
        in_pc = 32'h8000_0100;
        in_inst = INST_NOP;
        tick();
        in_valid = 0;
        check("postflush_pc", out_pc, 32'h8000_0100);
        check("postflush_count", 32'(count), 32'd1);
        out_ready = 1;
        tick();
        out_ready = 0;
        check("postflush_drain", 32'(count), 32'd0);

        in_valid = 1;
        in_pc = 32'h8000_00A0;
        tick();
        in_pc = 32'h8000_00A4;
        tick();
        check("premid_count", 32'(count), 32'd2);
        rst = 1;
        in_pc = 32'h0000_0BAD;
        tick();
        rst = 0;
        in_valid = 0;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1;
        in_pc = 32'h8000_0200;
        in_inst = 32'h0010_0093;
        tick();
        in_valid = 0;
        check("resume_valid", 32'(out_valid), 32'd1);
        check("resume_pc", out_pc, 32'h8000_0200);
        check("resume_inst", out_inst, 32'h0010_0093);
        check("resume_count", 32'(count), 32'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Decoupling FIFO directly downstream of the fetch unit, upstream of decode.
- Captures {pc, inst} pairs produced by fetch and presents them in order to decode via valid/ready.
- Absorbs decode stalls without back-pressuring fetch every cycle.
- Flush input discards all buffered instructions on a control-flow redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- XLEN, 32, width of pc and inst fields.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  fetch presents a valid {in_pc, in_inst}.
- in_ready  output  1  queue can accept; equals !full.
- in_pc  input  XLEN  address of fetched instruction.
- in_inst  input  XLEN  fetched instruction word.
- out_valid  output  1  head entry valid; equals !empty.
- out_ready  input  1  decode accepts head entry.
- out_pc  output  XLEN  head pc; 0 when empty.
- out_inst  output  XLEN  head inst; 0 when empty.
- flush  input  1  discard all contents this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- Reset (rst=1 at edge):
  - wr_ptr, rd_ptr and count go to 0; out_valid=0, in_ready=1, out_pc/out_inst=0.
  - Storage contents are don't-care.
  - Reset mid-stream drops all entries and any same-cycle push.
- First-word-fall-through: head entry drives out_pc/out_inst combinationally from storage[rd_ptr], masked to 0 when empty.
- Latency: a push into an empty queue appears as out_valid=1 in the next cycle. There is no same-cycle bypass.
- in_ready depends only on registered count (!full), never on out_ready. There is no combinational in→out or out_ready→in_ready path.
- Push only: storage[wr_ptr] <= {in_pc, in_inst}, wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop together (possible only when 0<count<DEPTH): both pointers advance, count unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- full = (count==DEPTH). empty = (count==0).
- Push when full is impossible (in_ready=0); in_valid is ignored.
- Pop when empty is impossible (out_valid=0); out_ready is ignored.
- Flush (priority below rst, above push/pop):
  - Next cycle wr_ptr=rd_ptr=0 and count=0.
  - A same-cycle push is dropped.
  - A same-cycle pop is still seen by decode as a handshake, but its effect is overridden.
- Upstream protocol: fetch holds in_pc/in_inst stable while in_valid & !in_ready. The queue does not check this.
- count never exceeds DEPTH or underflows. Verification asserts 0 <= count <= DEPTH every cycle.

Decomposition:
- Shared package (core-wide):
  - XLEN = 32.
  - RESET_PC = 32'h8000_0000.
  - INST_NOP = 32'h0000_0013.
  - typedef fetch_pkt_t {pc[XLEN-1:0], inst[XLEN-1:0]}, used by fetch, this queue and decode.
- No sub-module required; storage array, pointers and counter are inline.
- A generic sync FIFO is not factored out, because flush semantics are specific to this block.

Test Plan:
- Reset then idle:
  - rst=1 for 2 cycles, then 0 → count=0, out_valid=0, in_ready=1, out_pc=0, out_inst=0.
- Single push:
  - Push {0x8000_0000, 0x0000_0013} with out_ready=0 → next cycle out_valid=1, out_pc=0x8000_0000, out_inst=0x13, count=1.
- Fill to full:
  - Push pcs 0x8000_0000, +4, +8, +C with out_ready=0 → count=4, in_ready=0.
  - A 5th in_valid is held with no state change.
  - Then out_ready=1 → pcs emerge in order, one per cycle.
- Simultaneous push/pop with wrap-around:
  - Continuous in_valid=out_ready=1 for 10 cycles, pcs incrementing by 4 from 0x8000_0000 → count stays 1.
  - Output pc sequence equals input sequence delayed by 1 cycle; pointers wrap twice.
- Flush:
  - With count=3, assert flush together with in_valid=1 → next cycle count=0, out_valid=0.
  - The pushed entry never appears.
  - A subsequent push of pc 0x8000_0100 is the next output.
- Reset mid-operation:
  - count=2, assert rst for one cycle with in_valid=1 → next cycle count=0, out_valid=0.
  - Normal operation resumes on the following push.
